ex_mem_skid: RTL and testbench
==============================

// Module: ex_mem_skid
// PURPOSE
//  Two-entry skid buffer between the 32-bit ALU (alu32) and the memory stage.
//  Captures the ALU result (sum, zout, nout) and the instruction's forwarded
//  control, and resolves the branch condition when the entry is accepted.
//  Upstream sees an in_valid/in_ready handshake and downstream an
//  out_valid/out_ready handshake, so memory stalls never force a combinational
//  ALU hold.
// PARAMETERS
//  DW    32  data width of sum and wdata
//  RW    5   destination register index width
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-high reset
//  flush        in   1   synchronous; discard all entries this cycle
//  in_valid     in   1   ALU stage presents an entry
//  in_ready     out  1   buffer can accept (registered, not full)
//  sum          in   DW  ALU result
//  zout         in   1   ALU zero flag
//  nout         in   1   ALU negative flag (sum[31])
//  rd           in   RW  destination register
//  regwrite     in   1   write-back enable
//  memread      in   1   load
//  memwrite     in   1   store
//  wdata        in   DW  store data (rt value)
//  branch_op    in   2   00 none, 01 beq, 10 bne, 11 bltz
//  out_valid    out  1   head entry valid
//  out_ready    in   1   memory stage accepts head
//  out_sum, out_rd, out_regwrite, out_memread, out_memwrite, out_wdata
//               out  -   head entry fields (same widths as the inputs)
//  out_taken    out  1   head entry's resolved branch decision
//  last_z       out  1   sticky zout of the most recently accepted entry
//  last_n       out  1   sticky nout of the most recently accepted entry
//  count        out  2   occupancy 0..2
// BEHAVIOUR
//  - FSM states: EMPTY (count=0), ONE (1), FULL (2). Storage: head and tail slots.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (state != FULL). out_valid = (state != EMPTY).
//    Both are registered; neither depends combinationally on in_valid or out_ready.
//  - Outputs are driven only from the head slot, with zero combinational path from the inputs.
//  - Taken flag, computed on push and stored with the entry:
//    - 01: zout
//    - 10: ~zout
//    - 11: nout
//    - 00: 0
//  - Transitions:
//    - EMPTY, push: ONE, and the entry is written to head.
//    - ONE, push & !pop: FULL, and the entry is written to tail.
//    - ONE, push & pop: stays ONE, and head is overwritten with the new entry the same edge.
//    - ONE, pop & !push: EMPTY.
//    - FULL, pop: ONE, and tail moves to head. No push is possible in FULL (in_ready=0).
//  - The entry accepted first is always presented first (FIFO order, no reordering).
//  - flush: on the next edge state=EMPTY and count=0. flush dominates push and pop.
//    last_z and last_n are not changed by flush.
//  - last_z and last_n update on every push to that entry's zout and nout. They hold otherwise.
//  - Reset (asynchronous, any state, including mid-transfer):
//    - state=EMPTY, count=0, in_ready=1, out_valid=0, out_taken=0, last_z=0, last_n=0.
//    - All out_* data fields are 0. Slot contents are cleared to 0.
//  - Latency: an entry pushed at edge k is visible on out_* after edge k (1 cycle).
//    Sustained throughput is 1 entry per cycle when out_ready=1.
//  - An entry with x on sum must not corrupt state. Control bits are always known.
// TESTING
//  T1 reset asserted mid-FULL -> in_ready=1, out_valid=0, count=0, last_z=0 immediately (async).
//  T2 push sum=32'h0000_0005, rd=3, regwrite=1, out_ready=1 each cycle for 4 cycles
//     -> out_sum follows 1 cycle later; count stays 1; in_ready stays 1.
//  T3 out_ready=0, push A=32'h11 then B=32'h22 -> count=2, in_ready=0.
//     Hold in_valid with C=32'h33 -> C not taken.
//     Release out_ready -> A, B, C are delivered in that order.
//  T4 branch_op=01 with zout=1 -> out_taken=1.
//     branch_op=10 with zout=1 -> out_taken=0.
//     branch_op=11 with nout=1 (sum=32'hFFFF_FFFF) -> out_taken=1, last_n=1.
//  T5 count=2, assert flush together with in_valid -> next cycle count=0, out_valid=0, nothing pushed.
//  T6 count=1 with simultaneous push and pop -> count stays 1, out_sum is the new value next cycle.

Source files
------------

// File: rtl/ex_mem_skid.sv
// ex_mem_skid
//   Two-entry skid buffer between the ALU stage and the memory stage. It
//   captures the ALU result and the forwarded control of one instruction per
//   entry. The branch decision is resolved when the entry is accepted and is
//   stored with it. FIFO order is preserved. A memory-stage stall never
//   reaches back into the ALU combinationally.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   flush             discard every entry on the next edge (beats push/pop)
//   in_valid/in_ready upstream handshake; in_ready = not full
//   sum, zout, nout   ALU result and flags
//   rd, regwrite, memread, memwrite, wdata, branch_op
//                     forwarded control for the instruction
//   out_valid/out_ready downstream handshake; out_valid = not empty
//   out_*             head entry fields, including the resolved out_taken
//   last_z, last_n    flags of the most recently accepted entry
//   count             occupancy 0..2
module ex_mem_skid #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] sum,
   input  logic          zout,
   input  logic          nout,
   input  logic [RW-1:0] rd,
   input  logic          regwrite,
   input  logic          memread,
   input  logic          memwrite,
   input  logic [DW-1:0] wdata,
   input  logic [1:0]    branch_op,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_sum,
   output logic [RW-1:0] out_rd,
   output logic          out_regwrite,
   output logic          out_memread,
   output logic          out_memwrite,
   output logic [DW-1:0] out_wdata,
   output logic          out_taken,
   output logic          last_z,
   output logic          last_n,
   output logic [1:0]    count
);

   // The encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [DW-1:0] sum;
      logic [RW-1:0] rd;
      logic          regwrite;
      logic          memread;
      logic          memwrite;
      logic [DW-1:0] wdata;
      logic          taken;
   } entry_t;

   state_t state_q, state_d;
   entry_t head_q, head_d;
   entry_t tail_q, tail_d;
   entry_t new_entry;
   logic   last_z_q, last_z_d;
   logic   last_n_q, last_n_d;
   logic   taken;
   logic   push;
   logic   pop;

   // Branch resolution from the flags of the entry being accepted.
   always_comb begin
      taken = 1'b0;
      case (branch_op)
         2'b01:   taken = zout;   // beq
         2'b10:   taken = ~zout;  // bne
         2'b11:   taken = nout;   // bltz
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      new_entry          = '0;
      new_entry.sum      = sum;
      new_entry.rd       = rd;
      new_entry.regwrite = regwrite;
      new_entry.memread  = memread;
      new_entry.memwrite = memwrite;
      new_entry.wdata    = wdata;
      new_entry.taken    = taken;
   end

   always_comb begin
      state_d  = state_q;
      head_d   = head_q;
      tail_d   = tail_q;
      last_z_d = last_z_q;
      last_n_d = last_n_q;
      // Handshakes use only the state register, never each other's inputs.
      // flush suppresses both, so nothing is accepted or retired that cycle.
      push = in_valid && (state_q != FULL) && !flush;
      pop  = out_ready && (state_q != EMPTY) && !flush;

      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (push) begin
                  head_d  = new_entry;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (push && pop) begin
                  // Head retires on this edge, so the newcomer takes its place.
                  head_d = new_entry;
               end else if (push) begin
                  tail_d  = new_entry;
                  state_d = FULL;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  head_d  = tail_q;
                  state_d = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end

      if (push) begin
         last_z_d = zout;
         last_n_d = nout;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= EMPTY;
         head_q   <= '0;
         tail_q   <= '0;
         last_z_q <= 1'b0;
         last_n_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         last_z_q <= last_z_d;
         last_n_q <= last_n_d;
      end
   end

   assign in_ready     = (state_q != FULL);
   assign out_valid    = (state_q != EMPTY);
   assign count        = state_q;
   assign out_sum      = head_q.sum;
   assign out_rd       = head_q.rd;
   assign out_regwrite = head_q.regwrite;
   assign out_memread  = head_q.memread;
   assign out_memwrite = head_q.memwrite;
   assign out_wdata    = head_q.wdata;
   assign out_taken    = head_q.taken;
   assign last_z       = last_z_q;
   assign last_n       = last_n_q;

endmodule

// File: tb/tb_ex_mem_skid.sv
// tb_ex_mem_skid
//   Scoreboard bench for ex_mem_skid. The stimulus side queues every entry
//   it sees accepted, with the branch decision worked out from the opcode
//   table. A separate monitor retires entries in FIFO order whenever the DUT
//   hands one downstream. It also checks occupancy, the handshakes and the
//   sticky flags against the queue.
module tb_ex_mem_skid;

   localparam int DW = 32;
   localparam int RW = 5;
   localparam int EW = DW + RW + 3 + DW + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] sum = '0;
   logic          zout = 1'b0;
   logic          nout = 1'b0;
   logic [RW-1:0] rd = '0;
   logic          regwrite = 1'b0;
   logic          memread = 1'b0;
   logic          memwrite = 1'b0;
   logic [DW-1:0] wdata = '0;
   logic [1:0]    branch_op = 2'b00;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_sum;
   logic [RW-1:0] out_rd;
   logic          out_regwrite;
   logic          out_memread;
   logic          out_memwrite;
   logic [DW-1:0] out_wdata;
   logic          out_taken;
   logic          last_z;
   logic          last_n;
   logic [1:0]    count;

   ex_mem_skid #(.DW(DW), .RW(RW)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .sum(sum), .zout(zout), .nout(nout), .rd(rd),
      .regwrite(regwrite), .memread(memread), .memwrite(memwrite),
      .wdata(wdata), .branch_op(branch_op),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_rd(out_rd), .out_regwrite(out_regwrite),
      .out_memread(out_memread), .out_memwrite(out_memwrite),
      .out_wdata(out_wdata), .out_taken(out_taken),
      .last_z(last_z), .last_n(last_n), .count(count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: queued entries (the newest may still be pending for
   // the coming edge), and the sticky flags as they should read now.
   logic [EW-1:0] q[$];
   int   pend = 0;
   logic lz = 1'b0, ln = 1'b0;
   logic nz = 1'b0, nn = 1'b0;
   int   ncycle = 0;

   task automatic check_e(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, ncycle, act, exp);
      end
   endtask

   task automatic check_i(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", name, ncycle, act, exp);
      end
   endtask

   task automatic check_b(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %b expected %b", name, ncycle, act, exp);
      end
   endtask

   function automatic logic ref_taken(input logic [1:0] bop, input logic z, input logic n);
      if (bop == 2'b01) return z;
      if (bop == 2'b10) return !z;
      if (bop == 2'b11) return n;
      return 1'b0;
   endfunction

   // One cycle of stimulus, applied just after the rising edge. in_ready
   // comes only from state, so it is settled for this whole cycle here.
   task automatic step(input logic v, input logic [DW-1:0] s, input logic [RW-1:0] r,
                       input logic [2:0] ctl, input logic [DW-1:0] wd,
                       input logic [1:0] bop, input logic ordy, input logic fl);
      logic z;
      logic n;
      @(posedge clk);
      #1;
      z = (s == '0);
      n = s[DW-1];
      in_valid = v; sum = s; zout = z; nout = n; rd = r;
      regwrite = ctl[2]; memread = ctl[1]; memwrite = ctl[0];
      wdata = wd; branch_op = bop; out_ready = ordy; flush = fl;
      if (v && in_ready && !fl) begin
         q.push_back({s, r, ctl, wd, ref_taken(bop, z, n)});
         pend = 1;
         nz = z;
         nn = n;
         $display("[TB] cyc %0d push sum=%08h rd=%0d bop=%b", ncycle, s, r, bop);
      end
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, '0, '0, 3'b000, '0, 2'b00, ordy, 1'b0);
   endtask

   // Monitor: compares at the falling edge, then applies what the coming
   // rising edge will do to the reference state.
   always @(negedge clk) begin
      int exp_cnt;
      logic [EW-1:0] e;
      ncycle++;
      if (!reset) begin
         exp_cnt = q.size() - pend;
         check_i("count", int'(count), exp_cnt);
         check_b("in_ready", in_ready, exp_cnt != 2);
         check_b("out_valid", out_valid, exp_cnt != 0);
         check_b("last_z", last_z, lz);
         check_b("last_n", last_n, ln);
         if (flush) begin
            q.delete();
            $display("[TB] cyc %0d flush", ncycle);
         end else if (out_valid && out_ready) begin
            if (exp_cnt == 0) begin
               check_b("unexpected_out", out_valid, 1'b0);
            end else begin
               e = q.pop_front();
               check_e("head_entry",
                       {out_sum, out_rd, out_regwrite, out_memread, out_memwrite, out_wdata, out_taken}, e);
               $display("[TB] cyc %0d pop sum=%08h taken=%b", ncycle, out_sum, out_taken);
            end
         end
         if (pend != 0) begin
            lz = nz;
            ln = nn;
         end
         pend = 0;
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Back-to-back traffic with downstream always ready.
      repeat (4) step(1'b1, 32'h0000_0005, 5'd3, 3'b100, '0, 2'b00, 1'b1, 1'b0);
      idle(1'b1);

      // Fill while stalled, then hold C until there is room.
      step(1'b1, 32'h11, 5'd1, 3'b100, 32'hA, 2'b00, 1'b0, 1'b0);
      step(1'b1, 32'h22, 5'd2, 3'b010, 32'hB, 2'b00, 1'b0, 1'b0);
      step(1'b1, 32'h33, 5'd3, 3'b001, 32'hC, 2'b00, 1'b0, 1'b0);
      step(1'b1, 32'h33, 5'd3, 3'b001, 32'hC, 2'b00, 1'b1, 1'b0);
      step(1'b1, 32'h33, 5'd3, 3'b001, 32'hC, 2'b00, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);

      // Branch resolution for each opcode.
      step(1'b1, 32'h0, 5'd4, 3'b000, '0, 2'b01, 1'b1, 1'b0);
      step(1'b1, 32'h0, 5'd5, 3'b000, '0, 2'b10, 1'b1, 1'b0);
      step(1'b1, 32'hFFFF_FFFF, 5'd6, 3'b000, '0, 2'b11, 1'b1, 1'b0);
      step(1'b1, 32'h7, 5'd7, 3'b000, '0, 2'b10, 1'b1, 1'b0);
      idle(1'b1);

      // Flush while full with in_valid high, then flush while one entry held.
      step(1'b1, 32'h44, 5'd8, 3'b100, '0, 2'b00, 1'b0, 1'b0);
      step(1'b1, 32'h55, 5'd9, 3'b100, '0, 2'b00, 1'b0, 1'b0);
      step(1'b1, 32'h66, 5'd10, 3'b100, '0, 2'b00, 1'b0, 1'b1);
      idle(1'b0);
      step(1'b1, 32'h77, 5'd11, 3'b100, '0, 2'b00, 1'b0, 1'b0);
      step(1'b1, 32'h88, 5'd12, 3'b100, '0, 2'b00, 1'b1, 1'b1);
      idle(1'b1);

      // Simultaneous push and pop with one entry held.
      step(1'b1, 32'h99, 5'd13, 3'b100, '0, 2'b00, 1'b0, 1'b0);
      step(1'b1, 32'hAA, 5'd14, 3'b100, '0, 2'b00, 1'b1, 1'b0);
      idle(1'b0);
      idle(1'b1);

      // Asynchronous reset while full, with last_z set.
      step(1'b1, 32'h0, 5'd15, 3'b100, '0, 2'b01, 1'b0, 1'b0);
      step(1'b1, 32'h0, 5'd16, 3'b100, '0, 2'b01, 1'b0, 1'b0);
      @(posedge clk);
      #3;
      in_valid = 1'b0;
      reset = 1'b1;
      #1;
      check_b("rst_in_ready", in_ready, 1'b1);
      check_b("rst_out_valid", out_valid, 1'b0);
      check_i("rst_count", int'(count), 0);
      check_b("rst_last_z", last_z, 1'b0);
      check_b("rst_out_taken", out_taken, 1'b0);
      check_e("rst_out_fields",
              {out_sum, out_rd, out_regwrite, out_memread, out_memwrite, out_wdata, out_taken}, '0);
      $display("[TB] cyc %0d async reset while full", ncycle);
      q.delete();
      pend = 0;
      lz = 1'b0;
      ln = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         logic [DW-1:0] s;
         s = ($urandom_range(0, 5) == 0) ? '0 : DW'($urandom);
         step($urandom_range(0, 3) != 0, s, RW'($urandom), 3'($urandom), DW'($urandom),
              2'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      end

      // Drain, bounded.
      for (int i = 0; i < 8; i++) idle(1'b1);
      @(negedge clk);
      #1;
      check_i("drain_empty", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
